pll_lock_sequencer: RTL

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_seq_pkg.sv | 39 +++
 rtl/sync_2ff.sv | 31 +++
 rtl/pll_lock_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pll_seq_pkg
//  Brief    : Shared state encoding, default timing constants and counter
//             width helper for the PLL lock sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    // Default timing constants (cycles of refclk)
    localparam int c_DEF_PLL_RST_CYCLES      = 16;
    localparam int c_DEF_LOCK_FILTER_CYCLES  = 1024;
    localparam int c_DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int c_DEF_MAX_RETRIES         = 3;

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAILED    = 3'd4
    } state_t;

    // Width of the shared cycle counter: clog2 of the largest cycle count,
    // never narrower than one bit. Terminal compares use N-1, so clog2(N)
    // bits always suffice.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Brief    : 1-bit two-flop synchronizer, both stages reset to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of an asynchronous input into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_sequencer
//  Brief    : Holds the PLL in reset, waits for a filtered lock, then
//             releases the downstream system reset. Retries on lock timeout
//             and parks in FAILED after MAX_RETRIES failed attempts.
//  Revision : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = c_DEF_PLL_RST_CYCLES,
    parameter int LOCK_FILTER_CYCLES  = c_DEF_LOCK_FILTER_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = c_DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = c_DEF_MAX_RETRIES
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       status_ok,
    output logic       fail,
    output logic [3:0] retry_count
);

    localparam int c_CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_FILTER_CYCLES,
                                       LOCK_TIMEOUT_CYCLES);

    // Terminal counts: the counter starts at 0 on state entry, so a state
    // lasting N cycles ends when the counter reads N-1.
    localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_FLT_LAST = c_CNT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         c_RETRY_MAX = 4'(MAX_RETRIES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic [3:0]          r_retry;
    logic [3:0]          w_retry_nxt;
    logic [3:0]          w_retry_inc;
    logic                w_locked_s;

    sync_2ff u_sync_locked (
        .clk (refclk),
        .rst (rst),
        .i_d (pll_locked),
        .o_q (w_locked_s)
    );

    // Saturating increments: neither counter is allowed to wrap
    assign w_cnt_inc   = (r_cnt == {c_CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign w_retry_inc = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;

    // State, shared counter and retry count registers
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state <= ST_PLL_RESET;
            r_cnt   <= '0;
            r_retry <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_retry <= w_retry_nxt;
        end
    end

    // Next-state, counter and retry decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_retry_nxt = r_retry;
        case (r_state)
            ST_PLL_RESET: begin
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is checked first so it wins over a coincident timeout
                if (w_locked_s) begin
                    w_state_nxt = ST_FILTER;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TMO_LAST) begin
                    w_retry_nxt = w_retry_inc;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (w_retry_inc == c_RETRY_MAX) ? ST_FAILED
                                                               : ST_PLL_RESET;
                end
            end
            ST_FILTER: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_FLT_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = 4'd0;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = '0;
                if (!w_locked_s || relock_req) begin
                    w_state_nxt = ST_PLL_RESET;
                end
            end
            ST_FAILED: begin
                w_cnt_nxt = '0;
                if (relock_req) begin
                    w_state_nxt = ST_PLL_RESET;
                    w_retry_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt = ST_PLL_RESET;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Moore output decode from registered state only
    assign pll_rst     = (r_state == ST_PLL_RESET) || (r_state == ST_FAILED);
    assign sys_rst     = (r_state != ST_RUN);
    assign status_ok   = (r_state == ST_RUN);
    assign fail        = (r_state == ST_FAILED);
    assign retry_count = r_retry;

endmodule
`default_nettype wire
